demux_dispatch_ctrl: RTL
========================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Packet-level controller that sequences a 1-to-N_OUT demux.
//  - Takes one valid/ready input stream carrying a destination index.
//  - Holds the demux select stable for a whole packet, up to and including the beat flagged in_last.
//  - Buffers one beat per cycle toward the selected output.
//  - Drops packets addressed to a non-existent output and flags them.
//  - Sits between a single producer and the N_OUT consumer ports of the demux fabric.
// PARAMETERS
//  N_OUT  2  number of demux outputs (>=2)
//  DW     8  data width per beat
//  SW     $clog2(N_OUT) (localparam)  select/dest width; in_dest is one bit wider (SW+1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        input beat accepted when in_valid & in_ready
//  in_data    in   DW       input beat payload
//  in_dest    in   SW+1     destination index, sampled on a packet's first beat only
//  in_last    in   1        marks the final beat of a packet
//  out_valid  out  N_OUT    one-hot; only bit sel may be 1
//  out_ready  in   N_OUT    per-output ready
//  out_data   out  DW       shared payload to all demux outputs
//  sel        out  SW       demux select driven to the datapath
//  err_drop   out  1        1-cycle pulse: packet dropped (bad dest)
// BEHAVIOUR
//  - Reset values: state=IDLE, sel=0, out_valid=0, out_data=0, buffer empty, err_drop=0, in_ready=0.
//  - FSM states: IDLE, ROUTE, DRAIN, DROP.
//  - IDLE:
//    - in_ready=0; the first beat is peeked but not consumed.
//    - On in_valid: sel<=in_dest[SW-1:0].
//    - If in_dest<N_OUT -> ROUTE, else -> DROP with err_drop=1 next cycle.
//    - Cost: one bubble per packet.
//  - ROUTE:
//    - in_ready = ~buf_valid | out_ready[sel].
//    - An accepted beat loads the one-beat output register, giving 1-cycle latency in->out.
//    - out_valid[sel]=buf_valid.
//    - Simultaneous drain and accept: buffer stays valid with the new beat, so full throughput is 1 beat/cycle.
//    - Accepting an in_last beat -> DRAIN.
//  - DRAIN:
//    - in_ready=0; sel is held.
//    - When the buffer empties (out_ready[sel] & buf_valid, or already empty) -> IDLE.
//  - DROP:
//    - in_ready=1; beats are discarded and out_valid stays 0.
//    - Accepting an in_last beat -> IDLE.
//  - Single-beat packet (in_last on the first beat): ROUTE accepts it and goes straight to DRAIN.
//  - sel changes only in IDLE, never while the buffer holds data.
//  - out_data holds its value while out_valid=1 & ~out_ready[sel].
//  - rst asserted mid-packet: the buffered beat is discarded, the FSM returns to IDLE, and the next beat is treated as a new header.
// CONFIGURATION
//  DEMUX_DISPATCH_RR_EN
//  - Defined:
//    - in_dest is ignored; sel comes from a round-robin pointer.
//    - Pointer reset value is 0; it increments mod N_OUT on each DRAIN->IDLE transition.
//    - DROP is unreachable and err_drop is tied to 0.
//  - Undefined: destination-based routing as described above.
// STRUCTURE
//  - demux_dispatch_pkg: state_t enum (IDLE, ROUTE, DRAIN, DROP) and its encodings.
//  - Sub-module dispatch_out_reg: the one-beat output buffer (valid/data register with load/drain).
//  - All FSM and select logic lives in the top-level block.
// TESTING
//  - Reset: hold rst 2 cycles -> all outputs 0 and in_ready=0 on the cycle after release.
//  - 3-beat packet, dest=1, data A1,A2,A3, out_ready=all 1:
//    - sel=1 from the cycle after the header is seen; out_valid=2'b10 carries A1..A3 on consecutive cycles.
//    - out_valid[0] is never set; FSM returns to IDLE after DRAIN.
//  - Backpressure: dest=0, out_ready[0] low for 3 cycles mid-packet:
//    - in_ready=0 while the buffer is full; out_data stable; no beat lost or duplicated.
//  - Bad dest=2 (N_OUT=2), 2-beat packet:
//    - err_drop pulses once, both beats consumed, out_valid=0 throughout.
//    - A following dest=0 packet routes normally.
//  - Back-to-back single-beat packets, dest 0 then 1: sel stays 0 until the first beat drains, then switches to 1.
//  - rst pulse while the buffer is valid mid-packet: out_valid drops to 0 the next cycle; the next input beat is routed by its own in_dest.
//  - With DEMUX_DISPATCH_RR_EN: four 1-beat packets, all dest=1 -> delivered to outputs 0,1,0,1.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// demux_dispatch_pkg: FSM state encoding shared by the demux dispatch controller
package demux_dispatch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2,
    DROP  = 2'd3
  } state_t;
endpackage

// File: rtl/demux_dispatch_ctrl_out_reg.sv
// dispatch_out_reg: one-beat output buffer with load/drain; load wins over drain
// Ports: load_i/data_i fill the buffer, drain_i empties it, valid_o/data_o present it
module dispatch_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q;
  logic [DW-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load_i | (valid_q & ~drain_i);
      data_q  <= load_i ? data_i : data_q;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: packet-level controller holding a 1-to-N_OUT demux select per packet
// Ports: in_* producer stream (in_dest read on header only), out_* shared data with
// one-hot valid, sel demux select, err_drop one-cycle pulse on a bad-destination packet.
// Option DEMUX_DISPATCH_RR_EN: round-robin select instead of in_dest, no drops.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter  int N_OUT = 2,
  parameter  int DW    = 8,
  localparam int SW    = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SW:0]      in_dest,
  input  logic             in_last,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    sel,
  output logic             err_drop
);
  state_t        state_q;
  logic [SW-1:0] sel_q;
  logic          buf_valid;
  logic          drain;
  logic          accept;
  assign drain    = buf_valid & out_ready[sel_q];
  assign in_ready = state_q == ROUTE ? ~buf_valid | out_ready[sel_q] : state_q == DROP;
  assign accept   = state_q == ROUTE & in_valid & in_ready;
  assign out_valid = buf_valid ? N_OUT'(1) << sel_q : '0;
  assign sel      = sel_q;

  dispatch_out_reg #(.DW(DW)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .drain_i (drain),
    .data_i  (in_data),
    .valid_o (buf_valid),
    .data_o  (out_data)
  );

`ifdef DEMUX_DISPATCH_RR_EN
  logic [SW-1:0] rr_q;
  assign err_drop = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sel_q   <= rr_q;
          state_q <= ROUTE;
        end
        ROUTE: if (accept & in_last) state_q <= DRAIN;
        DRAIN: if (drain | ~buf_valid) begin
          state_q <= IDLE;
          rr_q    <= rr_q == SW'(N_OUT - 1) ? '0 : rr_q + SW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic err_q;
  logic dest_ok;
  assign dest_ok  = in_dest < (SW+1)'(N_OUT);
  assign err_drop = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          sel_q   <= in_dest[SW-1:0];
          state_q <= dest_ok ? ROUTE : DROP;
          err_q   <= ~dest_ok;
        end
        ROUTE: if (accept & in_last) state_q <= DRAIN;
        DRAIN: if (drain | ~buf_valid) state_q <= IDLE;
        DROP:  if (in_valid & in_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`endif
endmodule
